// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed 4-digit hex display scanner with frame-synchronous updates.
// Define SEVEN_SEGMENT_SCANNER_LZB_EN to enable leading-zero blanking of digits 3..1.
module seven_segment_scanner #(
  parameter int DIVIDER = 1024,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        i_we,
  input  logic [15:0] i_data,
  output logic [3:0]  o_data,
  output logic [3:0]  o_digit,
  output logic        o_frame
);
  logic [15:0] cnt, cnt_n, disp, disp_n, pend;
  logic [1:0] dig, dig_n;
  logic pv, last, wrap, dark;
  // Outputs are registered from next-state values so they line up with cnt/dig/disp.
  always_comb begin
    last = cnt == 16'(DIVIDER - 1);
    wrap = last && dig == 2'd3;
    cnt_n = last ? 16'd0 : cnt + 16'd1;
    dig_n = last ? dig + 2'd1 : dig;
    disp_n = wrap ? (i_we ? i_data : pv ? pend : disp) : disp;
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    dark = dig_n == 2'd3 ? disp_n[15:12] == 4'd0 :
           dig_n == 2'd2 ? disp_n[15:8] == 8'd0 :
           dig_n == 2'd1 ? disp_n[15:4] == 12'd0 : 1'b0;
`else
    dark = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cnt <= '0;
      dig <= '0;
      disp <= '0;
      pend <= '0;
      pv <= 1'b0;
      o_digit <= 4'hf;
      o_data <= 4'h0;
      o_frame <= 1'b0;
    end else begin
      cnt <= cnt_n;
      dig <= dig_n;
      disp <= disp_n;
      if (i_we) pend <= i_data;
      pv <= !wrap && (pv || i_we);
      o_digit <= (cnt_n < 16'(BLANK) || dark) ? 4'hf : ~(4'b0001 << dig_n);
      o_data <= disp_n[4*dig_n +: 4];
      o_frame <= wrap;
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed frame-by-frame checks with DIVIDER=8, BLANK=2.
module tb_seven_segment_scanner;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic i_we = 1'b0;
  logic [15:0] i_data = 16'h0;
  logic [3:0] o_data, o_digit;
  logic o_frame;
  int n_checks = 0;
  int n_errors = 0;
  seven_segment_scanner #(.DIVIDER(8), .BLANK(2)) dut (
    .clk(clk), .rst_x(rst_x), .i_we(i_we), .i_data(i_data),
    .o_data(o_data), .o_digit(o_digit), .o_frame(o_frame)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit is_dark(input int d, input logic [15:0] v);
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
    return d != 0 && (v >> (4 * d)) == 16'h0;
`else
    return 1'b0;
`endif
  endfunction
  // Checks n cycles of a frame showing v; writes w1/w2 are sampled on the edge ending that index.
  task automatic frame(input logic [15:0] v, input bit first, input int n,
                       input int w1, input logic [15:0] d1, input int w2, input logic [15:0] d2);
    for (int i = 0; i < n; i++) begin
      int d, k;
      logic [3:0] ed;
      d = i / 8;
      k = i % 8;
      ed = (k < 2 || is_dark(d, v)) ? 4'hf : ~(4'b0001 << d);
      check($sformatf("digit[%0d]", i), {12'h0, o_digit}, {12'h0, ed});
      check($sformatf("data[%0d]", i), {12'h0, o_data}, {12'h0, v[4*d +: 4]});
      check($sformatf("frame[%0d]", i), {15'h0, o_frame}, {15'h0, i == 0 && !first});
      i_we = (i == w1) || (i == w2);
      i_data = i == w1 ? d1 : i == w2 ? d2 : 16'h0;
      @(negedge clk);
    end
    i_we = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_digit", {12'h0, o_digit}, 16'h000f);
    check("rst_data", {12'h0, o_data}, 16'h0000);
    check("rst_frame", {15'h0, o_frame}, 16'h0000);
    rst_x = 1'b1;
    frame(16'h0000, 1'b1, 32, 9, 16'h1234, -1, 16'h0);
    frame(16'h1234, 1'b0, 32, 3, 16'haaaa, 20, 16'h5678);
    frame(16'h5678, 1'b0, 32, 31, 16'hbeef, -1, 16'h0);
    frame(16'hbeef, 1'b0, 32, -1, 16'h0, -1, 16'h0);
    frame(16'hbeef, 1'b0, 12, 5, 16'h9999, -1, 16'h0);
    rst_x = 1'b0;
    #1;
    check("async_digit", {12'h0, o_digit}, 16'h000f);
    check("async_data", {12'h0, o_data}, 16'h0000);
    check("async_frame", {15'h0, o_frame}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_x = 1'b1;
    frame(16'h0000, 1'b1, 32, 31, 16'h0005, -1, 16'h0);
    frame(16'h0005, 1'b0, 32, 31, 16'h0100, -1, 16'h0);
    frame(16'h0100, 1'b0, 32, -1, 16'h0, -1, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
